// File: rtl/rans_stream_decoder.sv
// rtl/rans_stream_decoder.sv - streaming rANS decoder with restoring divider and parallel symbol lookup
module rans_stream_decoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int SYM_COUNT   = 16,
    parameter int STATE_WIDTH = 32,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     ena_i,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0]           counts_unpacked_i,
    input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked_i,
    input  logic [LEN_WIDTH-1:0]                     sym_total_i,
    input  logic [SYM_WIDTH-1:0]                     in_i,
    input  logic                                     in_vld_i,
    output logic                                     in_rdy_o,
    output logic [SYM_WIDTH-1:0]                     out_o,
    output logic                                     out_last_o,
    output logic                                     out_vld_o,
    input  logic                                     out_rdy_i,
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int CW     = CNT_WIDTH + SYM_WIDTH;
    localparam int RW     = CW + 1;
    localparam int SW     = STATE_WIDTH;
    localparam int NWORDS = STATE_WIDTH / SYM_WIDTH;
    localparam int LCW    = $clog2(NWORDS + 1);
    localparam int DCW    = $clog2(STATE_WIDTH);

    typedef enum logic [2:0] {
        S_LOAD,
        S_DIV,
        S_LOOKUP,
        S_EMIT,
        S_UPDATE,
        S_RENORM,
        S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        x_q, x_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic [SW-1:0]        prod_q, prod_d;
    logic                 upd_ph_q, upd_ph_d;
    logic [DCW-1:0]       div_cnt_q, div_cnt_d;
    logic [LCW-1:0]       ld_cnt_q, ld_cnt_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [SYM_WIDTH-1:0] sym_q, sym_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic [CNT_WIDTH-1:0] cnt_a [SYM_COUNT];
    logic [CW-1:0]        cum_a [SYM_COUNT];
    logic [CW-1:0]        lo_a  [SYM_COUNT];
    logic [CNT_WIDTH-1:0] cnt_sel;
    logic [CW-1:0]        lo_sel;
    logic [SYM_WIDTH-1:0] lookup_s;
    logic                 lookup_hit;

    logic [CW-1:0]        m_total;
    logic [RW-1:0]        rem_shift;
    logic                 div_ge;
    logic [SW-1:0]        prod_new;
    logic [SW-1:0]        upd_x;
    logic [SW-1:0]        ren_x;
    logic [SW-1:0]        ld_x;

    // Slice the flat table buses into per-symbol entries.
    always_comb begin
        for (int j = 0; j < SYM_COUNT; j++) begin
            cnt_a[j] = counts_unpacked_i[j*CNT_WIDTH +: CNT_WIDTH];
            cum_a[j] = cumulative_unpacked_i[j*CW +: CW];
        end
    end

    // Lower bound of each symbol's slot range: the previous inclusive cumulative sum.
    always_comb begin
        lo_a[0] = '0;
        for (int j = 1; j < SYM_COUNT; j++) begin
            lo_a[j] = cum_a[j-1];
        end
    end

    // Parallel compare against every cumulative entry; lowest index that exceeds slot wins.
    always_comb begin
        lookup_s   = SYM_WIDTH'(SYM_COUNT - 1);
        lookup_hit = 1'b0;
        for (int j = 0; j < SYM_COUNT; j++) begin
            if (!lookup_hit && (cum_a[j] > rem_q)) begin
                lookup_s   = SYM_WIDTH'(j);
                lookup_hit = 1'b1;
            end
        end
    end

    // Fetch count and lower bound of the symbol just emitted.
    always_comb begin
        cnt_sel = '0;
        lo_sel  = '0;
        for (int j = 0; j < SYM_COUNT; j++) begin
            if (sym_q == SYM_WIDTH'(j)) begin
                cnt_sel = cnt_a[j];
                lo_sel  = lo_a[j];
            end
        end
    end

    assign m_total   = cum_a[SYM_COUNT-1];
    // Restoring divide: x_q shifts its MSB into the partial remainder and collects quotient bits at the LSB.
    assign rem_shift = {rem_q, x_q[SW-1]};
    assign div_ge    = (rem_shift >= {1'b0, m_total});
    // The state update is split over two cycles: product first, then the slot correction.
    assign prod_new  = SW'(cnt_sel) * x_q;
    assign upd_x     = prod_q + SW'(rem_q) - SW'(lo_sel);
    assign ren_x     = (x_q << SYM_WIDTH) | SW'(in_i);
    assign ld_x      = (x_q >> SYM_WIDTH) | (SW'(in_i) << (SW - SYM_WIDTH));

    // Next-state, datapath updates and handshake outputs; nothing advances while ena_i is low.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        rem_d       = rem_q;
        prod_d      = prod_q;
        upd_ph_d    = upd_ph_q;
        div_cnt_d   = div_cnt_q;
        ld_cnt_d    = ld_cnt_q;
        remaining_d = remaining_q;
        sym_d       = sym_q;
        last_d      = last_q;
        err_d       = err_q;

        in_rdy_o    = ena_i && ((state_q == S_LOAD) || (state_q == S_RENORM));
        out_vld_o   = ena_i && (state_q == S_EMIT);
        busy_o      = !((state_q == S_LOAD) && (ld_cnt_q == '0));

        if (ena_i) begin
            case (state_q)
                S_LOAD: begin
                    if (in_vld_i) begin
                        x_d = ld_x;
                        if (ld_cnt_q == '0) begin
                            remaining_d = sym_total_i;
                        end
                        if ((ld_cnt_q == '0) && (sym_total_i == '0)) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else if (ld_cnt_q == LCW'(NWORDS - 1)) begin
                            ld_cnt_d  = '0;
                            rem_d     = '0;
                            div_cnt_d = '0;
                            state_d   = S_DIV;
                        end else begin
                            ld_cnt_d = ld_cnt_q + LCW'(1);
                        end
                    end
                end
                S_DIV: begin
                    if ((div_cnt_q == '0) && (m_total == '0)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        x_d   = {x_q[SW-2:0], div_ge};
                        rem_d = div_ge ? CW'(rem_shift - {1'b0, m_total}) : rem_shift[CW-1:0];
                        if (div_cnt_q == DCW'(STATE_WIDTH - 1)) begin
                            div_cnt_d = '0;
                            state_d   = S_LOOKUP;
                        end else begin
                            div_cnt_d = div_cnt_q + DCW'(1);
                        end
                    end
                end
                S_LOOKUP: begin
                    sym_d   = lookup_s;
                    last_d  = (remaining_q == LEN_WIDTH'(1));
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (out_rdy_i) begin
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                        if (last_q) begin
                            state_d = S_LOAD;
                        end else begin
                            upd_ph_d = 1'b0;
                            state_d  = S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (!upd_ph_q) begin
                        prod_d   = prod_new;
                        upd_ph_d = 1'b1;
                    end else begin
                        upd_ph_d  = 1'b0;
                        x_d       = upd_x;
                        rem_d     = '0;
                        div_cnt_d = '0;
                        state_d   = (upd_x < SW'(m_total)) ? S_RENORM : S_DIV;
                    end
                end
                S_RENORM: begin
                    if (in_vld_i) begin
                        x_d = ren_x;
                        if (ren_x >= SW'(m_total)) begin
                            state_d = S_DIV;
                        end
                    end
                end
                S_ERR: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            x_q         <= '0;
            rem_q       <= '0;
            prod_q      <= '0;
            upd_ph_q    <= 1'b0;
            div_cnt_q   <= '0;
            ld_cnt_q    <= '0;
            remaining_q <= '0;
            sym_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            rem_q       <= rem_d;
            prod_q      <= prod_d;
            upd_ph_q    <= upd_ph_d;
            div_cnt_q   <= div_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            remaining_q <= remaining_d;
            sym_q       <= sym_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign out_o      = sym_q;
    assign out_last_o = last_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_rans_stream_decoder.sv
// tb/tb_rans_stream_decoder.sv - self-checking bench for rans_stream_decoder
module tb_rans_stream_decoder;

    localparam int SW   = 4;
    localparam int CNTW = 8;
    localparam int NS   = 16;
    localparam int STW  = 32;
    localparam int LW   = 16;
    localparam int CW   = CNTW + SW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena_i = 1'b1;
    logic [CNTW*NS-1:0]   counts_unpacked_i = '0;
    logic [CW*NS-1:0]     cumulative_unpacked_i = '0;
    logic [LW-1:0]        sym_total_i = '0;
    logic [SW-1:0]        in_i = '0;
    logic                 in_vld_i = 1'b0;
    logic                 in_rdy_o;
    logic [SW-1:0]        out_o;
    logic                 out_last_o;
    logic                 out_vld_o;
    logic                 out_rdy_i = 1'b0;
    logic                 busy_o;
    logic                 err_o;

    always #5 clk = ~clk;

    rans_stream_decoder #(
        .SYM_WIDTH(SW), .CNT_WIDTH(CNTW), .SYM_COUNT(NS), .STATE_WIDTH(STW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena_i(ena_i),
        .counts_unpacked_i(counts_unpacked_i), .cumulative_unpacked_i(cumulative_unpacked_i),
        .sym_total_i(sym_total_i), .in_i(in_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
        .out_o(out_o), .out_last_o(out_last_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] x;
        int          total;
        logic [15:0] rn;
        logic [15:0] syms;
        int          words;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cnt_t [NS];
    int unsigned cum_t [NS];
    logic [3:0]  wq [$];
    int          got_s [$];
    int          got_l [$];
    int          exp_s [$];
    int          ev_rise [$];
    int          ev_hs [$];
    int          ev_last_load;
    int          consumed;
    int          vld_samples;
    bit          overlap_bad;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_table();
        for (int j = 0; j < NS; j++) begin
            counts_unpacked_i[j*CNTW +: CNTW] = CNTW'(cnt_t[j]);
            cumulative_unpacked_i[j*CW +: CW] = CW'(cum_t[j]);
        end
    endtask

    task automatic set_uniform();
        for (int j = 0; j < NS; j++) begin
            cnt_t[j] = 16;
            cum_t[j] = 16 * (j + 1);
        end
        set_table();
    endtask

    task automatic set_random();
        int unsigned sum;
        sum = 0;
        for (int j = 0; j < NS; j++) begin
            cnt_t[j] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            sum += cnt_t[j];
            cum_t[j] = sum;
        end
        if (sum == 0) begin
            cnt_t[NS-1] = 1;
            cum_t[NS-1] = 1;
        end
        set_table();
    endtask

    task automatic load_x(input logic [31:0] x);
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(x[4*i +: 4]);
    endtask

    // Reference decode from the arithmetic definition; returns words consumed.
    function automatic int model_run(input logic [31:0] x0, input int total);
        longint unsigned x, q, slot, m, lo;
        int s, wi;
        exp_s.delete();
        m  = cum_t[NS-1];
        x  = x0;
        wi = 8;
        for (int i = 0; i < total; i++) begin
            q    = x / m;
            slot = x % m;
            s    = 0;
            while (s < NS - 1 && cum_t[s] <= slot) s++;
            exp_s.push_back(s);
            if (i == total - 1) break;
            lo = (s == 0) ? 0 : cum_t[s-1];
            x  = (cnt_t[s] * q + slot - lo) & 64'hFFFF_FFFF;
            while (x < m) begin
                if (wi >= wq.size()) return -1;
                x = ((x << 4) | wq[wi]) & 64'hFFFF_FFFF;
                wi++;
            end
        end
        return wi;
    endfunction

    task automatic do_reset();
        in_vld_i  = 1'b0;
        out_rdy_i = 1'b0;
        ena_i     = 1'b1;
        #2 rst_n  = 1'b0;
        @(posedge clk);
        #1 rst_n  = 1'b1;
    endtask

    // bp: 0 = out_rdy high, 1 = random out_rdy, 2 = hold each symbol 10 cycles.
    task automatic run_frame(input int total, input bit stall, input int bp);
        int wi, cyc, run_len;
        bit done, in_x, out_x, prev_vld;
        logic [3:0] snap_o;
        logic snap_l;
        got_s.delete(); got_l.delete(); ev_rise.delete(); ev_hs.delete();
        wi = 0; cyc = 0; run_len = 0; done = 0; prev_vld = 0;
        vld_samples = 0; overlap_bad = 0; ev_last_load = -1;
        snap_o = '0; snap_l = 1'b0;
        sym_total_i = LW'(total);
        while (!done && cyc < 20000) begin
            ena_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            case (bp)
                0:       out_rdy_i = 1'b1;
                1:       out_rdy_i = 1'($urandom_range(0, 1));
                default: out_rdy_i = (run_len >= 10);
            endcase
            in_vld_i = (wi < wq.size());
            in_i     = in_vld_i ? wq[wi] : 4'd0;
            #1;
            in_x  = in_vld_i && in_rdy_o && ena_i;
            out_x = out_vld_o && out_rdy_i && ena_i;
            if (in_rdy_o && out_vld_o) overlap_bad = 1;
            if (out_vld_o) begin
                vld_samples++;
                if (!prev_vld) ev_rise.push_back(cyc);
                if (bp == 2) begin
                    if (run_len == 0) begin
                        snap_o = out_o;
                        snap_l = out_last_o;
                    end else begin
                        check("hold out", out_o, snap_o);
                        check("hold out_last", out_last_o, snap_l);
                        check("hold in_rdy", in_rdy_o, 0);
                    end
                end
                run_len++;
            end else begin
                run_len = 0;
            end
            prev_vld = out_vld_o;
            if (out_x) begin
                got_s.push_back(int'(out_o));
                got_l.push_back(int'(out_last_o));
                ev_hs.push_back(cyc + 1);
                run_len = 0;
                if (out_last_o) done = 1;
            end
            if (in_x && wi == 7) ev_last_load = cyc + 1;
            @(posedge clk);
            #1;
            if (in_x) wi++;
            cyc++;
        end
        in_vld_i  = 1'b0;
        ena_i     = 1'b1;
        out_rdy_i = 1'b0;
        consumed  = wi;
        check("frame completes", done, 1);
    endtask

    task automatic verify_frame(input string tag, input int exp_words);
        check($sformatf("%s count", tag), got_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            check($sformatf("%s sym%0d", tag, i), got_s[i], exp_s[i]);
            check($sformatf("%s last%0d", tag, i), got_l[i], (i == exp_s.size() - 1) ? 1 : 0);
        end
        check($sformatf("%s words", tag), consumed, exp_words);
        check($sformatf("%s rdy/vld exclusive", tag), overlap_bad, 0);
        check($sformatf("%s err", tag), err_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        int   nw, total;
        bit   seen_rdy, seen_vld, err_low;
        logic [31:0] xr;

        vt[0] = '{x: 32'h0000_0123, total: 2, rn: 16'h0005, syms: 16'h0032, words: 9};
        vt[1] = '{x: 32'hABCD_EF12, total: 3, rn: 16'h0000, syms: 16'h0EF1, words: 8};
        vt[2] = '{x: 32'h0000_0876, total: 2, rn: 16'h000A, syms: 16'h0067, words: 9};
        vt[3] = '{x: 32'hFFFF_FFFF, total: 4, rn: 16'h0000, syms: 16'hFFFF, words: 8};
        vt[4] = '{x: 32'h0000_0010, total: 2, rn: 16'h0321, syms: 16'h0021, words: 11};

        set_uniform();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset in_rdy", in_rdy_o, 1);
        check("reset out_vld", out_vld_o, 0);
        check("reset out", out_o, 0);
        check("reset out_last", out_last_o, 0);
        check("reset err", err_o, 0);
        check("reset busy", busy_o, 0);
        @(posedge clk);
        #1;

        // Hand-derived uniform-table vectors.
        for (int i = 0; i < 5; i++) begin
            set_uniform();
            load_x(vt[i].x);
            for (int k = 0; k < 4; k++) wq.push_back(vt[i].rn[4*k +: 4]);
            exp_s.delete();
            for (int k = 0; k < vt[i].total; k++) exp_s.push_back(int'(vt[i].syms[4*k +: 4]));
            run_frame(vt[i].total, 1'b0, i % 2);
            verify_frame($sformatf("vec%0d", i), vt[i].words);
            check($sformatf("vec%0d in_rdy after frame", i), in_rdy_o, 1);
            check($sformatf("vec%0d busy after frame", i), busy_o, 0);
        end

        // Latency with out_rdy held high and no renormalisation.
        set_uniform();
        load_x(32'hFFFF_FFFF);
        run_frame(2, 1'b0, 0);
        check("lat first symbol", (ev_rise.size() > 0) ? ev_rise[0] - ev_last_load : -1, 33);
        check("lat symbol to symbol", (ev_rise.size() > 1 && ev_hs.size() > 0) ? ev_rise[1] - ev_hs[0] : -1, 35);
        check("emit single cycle", vld_samples, 2);

        // Backpressure: each symbol held for 10 cycles.
        set_uniform();
        load_x(32'hABCD_EF12);
        exp_s.delete();
        exp_s.push_back(1); exp_s.push_back(15); exp_s.push_back(14);
        run_frame(3, 1'b0, 2);
        verify_frame("backpressure", 8);

        // Random tables, random ena stalls and random out_rdy against the reference model.
        for (int f = 0; f < 12; f++) begin
            set_random();
            wq.delete();
            for (int k = 0; k < 8; k++) wq.push_back(4'($urandom_range(0, 15)));
            for (int k = 0; k < 64; k++) wq.push_back(4'($urandom_range(1, 15)));
            xr = '0;
            for (int k = 0; k < 8; k++) xr[4*k +: 4] = wq[k];
            total = $urandom_range(1, 8);
            nw = model_run(xr, total);
            run_frame(total, 1'b1, 1);
            verify_frame($sformatf("rand%0d", f), nw);
        end

        // Reset mid-divide, then a fresh frame.
        do_reset();
        set_uniform();
        load_x(32'h0000_0123);
        sym_total_i = 16'd2;
        for (int k = 0; k < 8; k++) begin
            in_vld_i = 1'b1;
            in_i     = wq[k];
            @(posedge clk);
            #1;
        end
        in_vld_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-div busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset in_rdy", in_rdy_o, 1);
        check("async reset out_vld", out_vld_o, 0);
        check("async reset out", out_o, 0);
        check("async reset out_last", out_last_o, 0);
        check("async reset err", err_o, 0);
        check("async reset busy", busy_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        load_x(32'h0000_0123);
        wq.push_back(4'd5);
        exp_s.delete();
        exp_s.push_back(2); exp_s.push_back(3);
        run_frame(2, 1'b0, 0);
        verify_frame("after reset", 9);

        // Zero table: error after load, never recovers.
        do_reset();
        for (int j = 0; j < NS; j++) begin
            cnt_t[j] = 0;
            cum_t[j] = 0;
        end
        set_table();
        load_x(32'h0000_0055);
        sym_total_i = 16'd1;
        out_rdy_i   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_vld_i = 1'b1;
            in_i     = wq[k];
            @(posedge clk);
            #1;
        end
        in_vld_i = 1'b1;
        @(posedge clk);
        #1;
        seen_rdy = 0; seen_vld = 0; err_low = 0;
        for (int c = 0; c < 40; c++) begin
            if (in_rdy_o) seen_rdy = 1;
            if (out_vld_o) seen_vld = 1;
            if (!err_o) err_low = 1;
            @(posedge clk);
            #1;
        end
        in_vld_i = 1'b0;
        check("zero table err held", err_low, 0);
        check("zero table in_rdy", seen_rdy, 0);
        check("zero table out_vld", seen_vld, 0);
        check("zero table busy", busy_o, 1);

        // sym_total = 0: error on the first load word.
        do_reset();
        set_uniform();
        sym_total_i = 16'd0;
        in_vld_i    = 1'b1;
        in_i        = 4'd3;
        #1;
        check("zero total err before", err_o, 0);
        @(posedge clk);
        #1;
        in_vld_i = 1'b0;
        check("zero total err", err_o, 1);
        check("zero total in_rdy", in_rdy_o, 0);
        repeat (5) @(posedge clk);
        #1;
        check("zero total err sticky", err_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
